// File: rtl/fp16b_accum_seq_if.sv
// Stream, datapath and result signals of the bf16 group accumulator.
// The accumulator uses the slave view; its environment uses the master view.
interface fp16b_accum_seq_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_sub;
  logic             in_last;
  logic [15:0]      add_x;
  logic [15:0]      add_y;
  logic             add_sub;
  logic             add_issue;
  logic [15:0]      add_res;
  logic             add_res_valid;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             err;

  modport slave (
    input  in_valid, in_data, in_sub, in_last, add_res, add_res_valid, out_ready,
    output in_ready, add_x, add_y, add_sub, add_issue, out_valid, out_data, out_count, err
  );

  modport master (
    output in_valid, in_data, in_sub, in_last, add_res, add_res_valid, out_ready,
    input  in_ready, add_x, add_y, add_sub, add_issue, out_valid, out_data, out_count, err
  );
endinterface

// File: rtl/fp16b_accum_seq.sv
// Sequential bf16 group accumulator: issues running-sum add/sub ops to an external
// fixed-latency datapath, waits for each result, and emits one sum per group.
module fp16b_accum_seq #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  fp16b_accum_seq_if.slave bus
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_acc;
  logic [15:0]      w_acc_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [TMO_W-1:0] r_tmo;
  logic             r_last;
  logic             w_accept;
  logic             w_tmo_hit;
  logic             r_in_ready;
  logic             r_add_issue;
  logic             r_add_sub;
  logic [15:0]      r_add_x;
  logic [15:0]      r_add_y;
  logic             r_out_valid;
  logic [15:0]      r_out_data;
  logic [CNT_W-1:0] r_out_count;
  logic             r_err;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus next accumulator/count values.
  always_comb begin
    w_next     = r_state;
    w_acc_next = r_acc;
    w_cnt_next = r_cnt;
    w_tmo_hit  = 1'b0;
    w_accept   = bus.in_valid & r_in_ready;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc_next = bus.in_data;
          w_cnt_next = CNT_W'(1);
          w_next     = bus.in_last ? S_DONE : S_ACC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ACC: begin
        if (w_accept) begin
          w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
          w_next     = S_ISSUE;
        end else begin
          w_next = S_ACC;
        end
      end
      S_ISSUE: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle wins over the timeout.
        if (bus.add_res_valid) begin
          w_acc_next = bus.add_res;
          w_next     = r_last ? S_DONE : S_ACC;
        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          w_tmo_hit = 1'b1;
          w_next    = r_last ? S_DONE : S_ACC;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_DONE: begin
        if (bus.out_ready & r_out_valid) begin
          w_cnt_next = {CNT_W{1'b0}};
          w_next     = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath state and outputs, all registered from the next-state decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= 16'h0000;
      r_cnt       <= {CNT_W{1'b0}};
      r_tmo       <= {TMO_W{1'b0}};
      r_last      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_add_issue <= 1'b0;
      r_add_sub   <= 1'b0;
      r_add_x     <= 16'h0000;
      r_add_y     <= 16'h0000;
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
      r_out_count <= {CNT_W{1'b0}};
      r_err       <= 1'b0;
    end else begin
      r_acc       <= w_acc_next;
      r_cnt       <= w_cnt_next;
      r_in_ready  <= (w_next == S_IDLE) || (w_next == S_ACC);
      r_add_issue <= (w_next == S_ISSUE);
      r_out_valid <= (w_next == S_DONE);
      if ((r_state == S_ACC) && w_accept) begin
        r_add_x   <= r_acc;
        r_add_y   <= bus.in_data;
        r_add_sub <= bus.in_sub;
        r_last    <= bus.in_last;
      end
      if (r_state == S_ISSUE) begin
        r_tmo <= {TMO_W{1'b0}};
      end else if (r_state == S_WAIT) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
      if (w_next == S_DONE) begin
        r_out_data  <= w_acc_next;
        r_out_count <= w_cnt_next;
      end
      if (w_tmo_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.add_issue = r_add_issue;
  assign bus.add_x     = r_add_x;
  assign bus.add_y     = r_add_y;
  assign bus.add_sub   = r_add_sub;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_count = r_out_count;
  assign bus.err       = r_err;
endmodule

// File: doc/fp16b_accum_seq.md
Name: fp16b_accum_seq

Overview:
- Sequential bfloat16 accumulator placed directly downstream of the 5-stage bfloat16 add/sub datapath (stages S0..S4, registered externally to a fixed latency).
- Consumes a valid/ready stream of bf16 operands grouped by a last flag.
- Issues running-sum add/sub operations into the datapath, waits for each result (read-after-write on the accumulator), and emits one bf16 sum per group with an element count.

Parameters:
- TIMEOUT, 64: max cycles from add issue to add_res_valid before the error flag sets.
- CNT_W, 16: width of the element counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when in_valid&in_ready.
- in_data  in  16  bf16 operand.
- in_sub  in  1  1: subtract operand from running sum; ignored on the first element of a group.
- in_last  in  1  operand is last of its group.
- add_x  out  16  datapath lhs (running sum).
- add_y  out  16  datapath rhs (operand).
- add_sub  out  1  datapath is_sub.
- add_issue  out  1  one-cycle strobe; datapath captures add_x/add_y/add_sub.
- add_res  in  16  datapath result.
- add_res_valid  in  1  result strobe.
- out_valid  out  1  group sum valid.
- out_ready  in  1  consumer accepts sum.
- out_data  out  16  bf16 group sum.
- out_count  out  CNT_W  elements in the group, saturating at all-ones.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; acc=0; count=0; all outputs 0; err=0.
- States: IDLE, ACC, ISSUE, WAIT, DONE.
- IDLE: in_ready=1.
  - On accept: acc<=in_data, count<=1.
  - Next state is DONE if in_last, else ACC.
  - No datapath op for the first element.
- ACC: in_ready=1.
  - On accept: latch operand, in_sub and in_last; count<=count+1, saturating.
  - Next state ISSUE.
- ISSUE: in_ready=0; add_issue=1 for exactly one cycle, with add_x=acc, add_y=operand, add_sub=in_sub. Next state WAIT; timeout counter cleared.
- WAIT: in_ready=0; timeout counter increments each cycle.
  - On add_res_valid: acc<=add_res; next state DONE if the latched last=1, else ACC.
  - If the counter reaches TIMEOUT: err<=1, acc unchanged, proceed as if a result arrived (last→DONE, else ACC).
- add_res_valid outside WAIT is ignored. An add_res_valid arriving in the same cycle as the timeout is accepted and does not set err.
- DONE: out_valid=1, out_data=acc, out_count=count.
  - Held stable until out_ready.
  - On out_valid&out_ready: next state IDLE, count<=0.
  - in_ready=0 in DONE, so there is no overlap between groups.
- add_x/add_y/add_sub hold their last issued values outside ISSUE.
- Throughput: one operand per (2 + datapath latency) cycles after the first.
- No bf16 arithmetic is done in this block; acc is replaced verbatim by add_res.
- err is cleared only by reset.
- Reset asserted mid-group (any state) aborts the group. A late add_res_valid after reset release lands in IDLE and is ignored.

Test Plan:
- Single-element group: in_data=0x3F80, last=1 → no add_issue; out_valid next cycle, out_data=0x3F80, out_count=1.
- Three-element sum (bench adder model, latency 5): 0x3F80, 0x4000, 0x3F00 (last) → two add_issue strobes with add_x=0x3F80 then 0x4040; out_data=0x4060, out_count=3.
- Subtraction: 0x4040, then 0x3F80 with in_sub=1, last → add_sub=1; out_data=0x4000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_data/out_count stable, in_ready=0 throughout; accept, then the next group starts from IDLE.
- Timeout: withhold add_res_valid → err=1 exactly TIMEOUT cycles after WAIT entry; out_data equals the pre-issue acc; err persists through later groups.
- Reset mid-WAIT: drop rst, then send a stray add_res_valid after release → outputs 0, state IDLE, stray result ignored, next group is correct.
